// File: rtl/pipe_stage_skid_reg.sv
// Handshaked pipeline-stage register with an optional skid slot.
// Flush kills held beats, and the control bundle reads CTRL_SAFE whenever the output is invalid.
module pipe_stage_skid_reg #(
    parameter int unsigned          CTRL_W    = 16,
    parameter int unsigned          DATA_W    = 165,
    parameter logic [CTRL_W-1:0]    CTRL_SAFE = {CTRL_W{1'b0}},
    parameter bit                   SKID_EN   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_up_valid,
    output logic              o_up_ready,
    input  logic [CTRL_W-1:0] i_up_ctrl,
    input  logic [DATA_W-1:0] i_up_data,
    input  logic              i_flush,
    output logic              o_dn_valid,
    input  logic              i_dn_ready,
    output logic [CTRL_W-1:0] o_dn_ctrl,
    output logic [DATA_W-1:0] o_dn_data,
    output logic [1:0]        o_occ
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              up_ready_q,   up_ready_d;
    logic [1:0]        occ_q,        occ_d;

    logic              up_ready_s;
    logic              up_accept_s;
    logic              dn_accept_s;

    // Without a skid slot, ready must look through to downstream in the same cycle.
    assign up_ready_s  = SKID_EN ? up_ready_q : (!main_valid_q || i_dn_ready);
    assign up_accept_s = i_up_valid && up_ready_s;
    assign dn_accept_s = main_valid_q && i_dn_ready;

    // Next-state for main/skid slots, the registered ready and the occupancy count.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        up_ready_d   = up_ready_q;
        occ_d        = occ_q;

        if (i_flush) begin
            // Any upstream beat in this cycle is discarded; data registers keep stale contents.
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_SAFE;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = CTRL_SAFE;
        end else if (SKID_EN) begin
            if (!main_valid_q) begin
                if (up_accept_s) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = i_up_ctrl;
                    main_data_d  = i_up_data;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (dn_accept_s) begin
                if (skid_valid_q) begin
                    // Ready was low, so no upstream beat can arrive alongside the refill.
                    main_ctrl_d  = skid_ctrl_q;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (up_accept_s) begin
                    main_ctrl_d  = i_up_ctrl;
                    main_data_d  = i_up_data;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else begin
                if (up_accept_s) begin
                    skid_valid_d = 1'b1;
                    skid_ctrl_d  = i_up_ctrl;
                    skid_data_d  = i_up_data;
                end else begin
                    skid_valid_d = skid_valid_q;
                end
            end
        end else begin
            if (up_accept_s) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = i_up_ctrl;
                main_data_d  = i_up_data;
            end else if (dn_accept_s) begin
                main_valid_d = 1'b0;
            end else begin
                main_valid_d = main_valid_q;
            end
        end

        if (SKID_EN) begin
            up_ready_d = !skid_valid_d;
        end else begin
            up_ready_d = 1'b1;
        end
        occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // State registers; reset leaves the stage empty with ready asserted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= CTRL_SAFE;
            main_data_q  <= {DATA_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= CTRL_SAFE;
            skid_data_q  <= {DATA_W{1'b0}};
            up_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            up_ready_q   <= up_ready_d;
            occ_q        <= occ_d;
        end
    end

    assign o_up_ready = up_ready_s;
    assign o_dn_valid = main_valid_q;
    assign o_dn_ctrl  = main_valid_q ? main_ctrl_q : CTRL_SAFE;
    assign o_dn_data  = main_data_q;
    assign o_occ      = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed and scoreboarded checks for pipe_stage_skid_reg, with and without the skid slot.
module tb_pipe_stage_skid_reg;

    localparam int CW = 16;
    localparam int DW = 165;

    logic          clk;
    logic          rst;
    logic          up_valid, up_ready, flush, dn_valid, dn_ready;
    logic [CW-1:0] up_ctrl, dn_ctrl;
    logic [DW-1:0] up_data, dn_data;
    logic [1:0]    occ;

    logic          s0_up_valid, s0_up_ready, s0_flush, s0_dn_valid, s0_dn_ready;
    logic [CW-1:0] s0_up_ctrl, s0_dn_ctrl;
    logic [DW-1:0] s0_up_data, s0_dn_data;
    logic [1:0]    s0_occ;

    int n_vec;
    int n_err;

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_up_valid(up_valid), .o_up_ready(up_ready),
        .i_up_ctrl(up_ctrl), .i_up_data(up_data),
        .i_flush(flush),
        .o_dn_valid(dn_valid), .i_dn_ready(dn_ready),
        .o_dn_ctrl(dn_ctrl), .o_dn_data(dn_data),
        .o_occ(occ)
    );

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst),
        .i_up_valid(s0_up_valid), .o_up_ready(s0_up_ready),
        .i_up_ctrl(s0_up_ctrl), .i_up_data(s0_up_data),
        .i_flush(s0_flush),
        .o_dn_valid(s0_dn_valid), .i_dn_ready(s0_dn_ready),
        .o_dn_ctrl(s0_dn_ctrl), .o_dn_data(s0_dn_data),
        .o_occ(s0_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        up_valid = v;
        up_ctrl  = c;
        up_data  = d;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [CW-1:0] c,
                           input logic [DW-1:0] d, input logic [1:0] o, input logic r);
        chk({tag, ".valid"}, 192'(dn_valid), 192'(v));
        chk({tag, ".ctrl"},  192'(dn_ctrl),  192'(c));
        if (v) chk({tag, ".data"}, 192'(dn_data), 192'(d));
        chk({tag, ".occ"},   192'(occ),      192'(o));
        chk({tag, ".ready"}, 192'(up_ready), 192'(r));
    endtask

    logic [CW+DW-1:0] q[$];
    logic             m_ready;
    logic             r_v, r_dr, r_fl;
    logic [191:0]     rnd;
    logic [CW-1:0]    r_c;
    logic [DW-1:0]    r_d;
    logic [CW+DW-1:0] head;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        drive(1'b0, 16'h0, '0);
        flush = 1'b0;
        dn_ready = 1'b0;
        s0_up_valid = 1'b0; s0_up_ctrl = 16'h0; s0_up_data = '0;
        s0_flush = 1'b0; s0_dn_ready = 1'b0;

        // Reset state
        #12;
        chk_out("reset", 1'b0, 16'h0000, '0, 2'd0, 1'b1);
        chk("reset.data", 192'(dn_data), 192'd0);
        chk("reset.s0_ready", 192'(s0_up_ready), 192'd1);
        chk("reset.s0_occ", 192'(s0_occ), 192'd0);
        #1 rst = 1'b0;
        tick();

        // Streaming: one beat per cycle, one cycle latency, no bubbles
        dn_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, {8'hA5, 8'(8'h10 + i)}, DW'(32'h10 + i));
            tick();
            chk_out($sformatf("stream%0d", i), 1'b1, {8'hA5, 8'(8'h10 + i)},
                    DW'(32'h10 + i), 2'd1, 1'b1);
        end
        drive(1'b0, 16'h0, '0);
        tick();
        chk_out("stream_end", 1'b0, 16'h0000, '0, 2'd0, 1'b1);

        // Backpressure: A held, B skidded, C refused until released
        dn_ready = 1'b0;
        drive(1'b1, 16'h0A0A, DW'(32'hA));
        tick();
        chk_out("bp_A", 1'b1, 16'h0A0A, DW'(32'hA), 2'd1, 1'b1);
        drive(1'b1, 16'h0B0B, DW'(32'hB));
        tick();
        chk_out("bp_B", 1'b1, 16'h0A0A, DW'(32'hA), 2'd2, 1'b0);
        drive(1'b1, 16'h0C0C, DW'(32'hC));
        tick();
        chk_out("bp_C1", 1'b1, 16'h0A0A, DW'(32'hA), 2'd2, 1'b0);
        tick();
        chk_out("bp_C2", 1'b1, 16'h0A0A, DW'(32'hA), 2'd2, 1'b0);
        dn_ready = 1'b1;
        tick();
        chk_out("bp_relB", 1'b1, 16'h0B0B, DW'(32'hB), 2'd1, 1'b1);
        tick();
        chk_out("bp_relC", 1'b1, 16'h0C0C, DW'(32'hC), 2'd1, 1'b1);
        drive(1'b0, 16'h0, '0);
        tick();
        chk_out("bp_empty", 1'b0, 16'h0000, '0, 2'd0, 1'b1);

        // Flush with two beats held and a beat D upstream
        dn_ready = 1'b0;
        drive(1'b1, 16'hFFFF, DW'(32'hE));
        tick();
        drive(1'b1, 16'hFFFF, DW'(32'hF));
        tick();
        chk_out("fl_full", 1'b1, 16'hFFFF, DW'(32'hE), 2'd2, 1'b0);
        drive(1'b1, 16'hFFFF, DW'(32'hD));
        flush = 1'b1;
        tick();
        chk_out("fl_after", 1'b0, 16'h0000, '0, 2'd0, 1'b1);
        flush = 1'b0;
        drive(1'b0, 16'h0, '0);
        dn_ready = 1'b1;
        tick();
        chk_out("fl_noD", 1'b0, 16'h0000, '0, 2'd0, 1'b1);
        // Flush beats an accepted upstream beat in the same cycle
        drive(1'b1, 16'hFFFF, DW'(32'h6));
        tick();
        chk_out("fl_G", 1'b1, 16'hFFFF, DW'(32'h6), 2'd1, 1'b1);
        drive(1'b1, 16'hFFFF, DW'(32'h7));
        flush = 1'b1;
        tick();
        chk_out("fl_H", 1'b0, 16'h0000, '0, 2'd0, 1'b1);
        flush = 1'b0;
        drive(1'b0, 16'h0, '0);
        tick();
        chk_out("fl_noH", 1'b0, 16'h0000, '0, 2'd0, 1'b1);

        // Asynchronous reset in the middle of a stream
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'h00FF, DW'(i));
            tick();
            chk_out($sformatf("mid%0d", i), 1'b1, 16'h00FF, DW'(i), 2'd1, 1'b1);
        end
        drive(1'b1, 16'h00FF, DW'(4));
        #2 rst = 1'b1;
        #1;
        chk_out("mid_rst", 1'b0, 16'h0000, '0, 2'd0, 1'b1);
        chk("mid_rst.data", 192'(dn_data), 192'd0);
        drive(1'b0, 16'h0, '0);
        #2 rst = 1'b0;
        tick();
        chk_out("mid_post", 1'b0, 16'h0000, '0, 2'd0, 1'b1);

        // Single-register build: combinational ready
        s0_dn_ready = 1'b0;
        s0_up_valid = 1'b1; s0_up_ctrl = 16'h1234; s0_up_data = DW'(32'h55);
        tick();
        chk("s0_X.valid", 192'(s0_dn_valid), 192'd1);
        chk("s0_X.ready", 192'(s0_up_ready), 192'd0);
        chk("s0_X.occ", 192'(s0_occ), 192'd1);
        s0_up_ctrl = 16'h5678; s0_up_data = DW'(32'h66);
        tick();
        chk("s0_hold.data", 192'(s0_dn_data), 192'h55);
        chk("s0_hold.ctrl", 192'(s0_dn_ctrl), 192'h1234);
        s0_dn_ready = 1'b1;
        #1;
        chk("s0_comb.ready", 192'(s0_up_ready), 192'd1);
        tick();
        chk("s0_Y.data", 192'(s0_dn_data), 192'h66);
        chk("s0_Y.ctrl", 192'(s0_dn_ctrl), 192'h5678);
        chk("s0_Y.occ", 192'(s0_occ), 192'd1);
        s0_up_valid = 1'b0;
        tick();
        chk("s0_end.valid", 192'(s0_dn_valid), 192'd0);
        chk("s0_end.ctrl", 192'(s0_dn_ctrl), 192'd0);
        chk("s0_end.occ", 192'(s0_occ), 192'd0);

        // Random traffic against a queue model of the skid build
        q.delete();
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r_v  = ($urandom_range(3) != 0);
            r_dr = ($urandom_range(2) != 0);
            r_fl = ($urandom_range(19) == 0);
            rnd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            r_c  = rnd[191:176];
            r_d  = rnd[DW-1:0];
            drive(r_v, r_c, r_d);
            dn_ready = r_dr;
            flush = r_fl;
            if (r_fl) begin
                q.delete();
            end else begin
                if (q.size() > 0 && r_dr) void'(q.pop_front());
                if (r_v && m_ready) q.push_back({r_c, r_d});
            end
            m_ready = (q.size() < 2);
            tick();
            if (q.size() > 0) begin
                head = q[0];
                chk_out($sformatf("rnd%0d", cyc), 1'b1, head[CW+DW-1:DW], head[DW-1:0],
                        2'(q.size()), m_ready);
            end else begin
                chk_out($sformatf("rnd%0d", cyc), 1'b0, 16'h0000, '0, 2'd0, m_ready);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
